// File: rtl/cpu_cmd_sequencer.sv
// Command master for the CPU op/ram/reg interface: accepts host commands, gathers
// OutToRam write data, issues exactly one CPU op per legal command and streams RamToOut results.
module cpu_cmd_sequencer #(
   parameter int          WORDS  = 16,
   parameter int          DATA_W = 32,
   parameter int          ADDR_W = 9,
   parameter logic [2:0]  NOP_OP = 3'b111
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [2:0]                cmd_op,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [3:0]                cmd_cnt,
   input  logic [1:0]                cmd_sel,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [DATA_W-1:0]         wr_data,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rd_last,
   output logic [2:0]                cpu_op,
   output logic [ADDR_W-1:0]         cpu_ram_addr,
   output logic [3:0]                cpu_ram_cnt,
   output logic [1:0]                cpu_reg_sel,
   output logic [WORDS*DATA_W-1:0]   cpu_ram_input,
   input  logic [WORDS*DATA_W-1:0]   cpu_ram_output,
   output logic                      busy,
   output logic                      done,
   output logic                      cmd_err
);

   localparam logic [2:0] OP_RAM_TO_OUT = 3'b100;
   localparam logic [2:0] OP_OUT_TO_RAM = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_ISSUE   = 3'd2,
      S_CAPTURE = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [3:0]          cnt_q;
   logic [1:0]          sel_q;
   logic [3:0]          idx_q;
   logic [ADDR_W-1:0]   hold_addr_q;
   logic [3:0]          hold_cnt_q;
   logic [1:0]          hold_sel_q;
   logic [DATA_W-1:0]   data_buf [WORDS];
   logic                done_q;
   logic                err_q;

   // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
   // a valid source holds its payload until that edge.
   logic cmd_accept;
   logic cmd_legal;
   logic wr_fire;
   logic rd_fire;
   logic at_last;

   assign cmd_accept = (state_q == S_IDLE) && cmd_valid;
   assign cmd_legal  = (cmd_op <= OP_OUT_TO_RAM);
   assign at_last    = (idx_q == cnt_q);
   assign wr_fire    = (state_q == S_FILL) && wr_valid;
   assign rd_fire    = (state_q == S_DRAIN) && rd_ready;

   always_comb begin
      state_d       = state_q;
      cmd_ready     = 1'b0;
      wr_ready      = 1'b0;
      rd_valid      = 1'b0;
      rd_last       = 1'b0;
      rd_data       = '0;
      cpu_op        = NOP_OP;
      cpu_ram_addr  = hold_addr_q;
      cpu_ram_cnt   = hold_cnt_q;
      cpu_reg_sel   = hold_sel_q;
      cpu_ram_input = '0;
      busy          = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && cmd_legal) begin
               state_d = (cmd_op == OP_OUT_TO_RAM) ? S_FILL : S_ISSUE;
            end
         end
         S_FILL: begin
            wr_ready = 1'b1;
            if (wr_valid && at_last) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            cpu_op       = op_q;
            cpu_ram_addr = addr_q;
            cpu_ram_cnt  = cnt_q;
            cpu_reg_sel  = sel_q;
            for (int i = 0; i < WORDS; i++) begin
               cpu_ram_input[i*DATA_W +: DATA_W] = data_buf[i];
            end
            state_d = (op_q == OP_RAM_TO_OUT) ? S_CAPTURE : S_IDLE;
         end
         S_CAPTURE: begin
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            rd_valid = 1'b1;
            rd_data  = data_buf[idx_q];
            rd_last  = at_last;
            if (rd_ready && at_last) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= NOP_OP;
         addr_q      <= '0;
         cnt_q       <= '0;
         sel_q       <= '0;
         idx_q       <= '0;
         hold_addr_q <= '0;
         hold_cnt_q  <= '0;
         hold_sel_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= ((state_q == S_ISSUE) && (op_q != OP_RAM_TO_OUT)) || (rd_fire && at_last);
         err_q   <= cmd_accept && !cmd_legal;
         if (cmd_accept) begin
            op_q   <= cmd_op;
            addr_q <= cmd_addr;
            cnt_q  <= cmd_cnt;
            sel_q  <= cmd_sel;
            idx_q  <= '0;
         end
         // idx stops at cnt so a 16-word transfer never wraps back to slot 0
         if (wr_fire && !at_last) idx_q <= idx_q + 4'd1;
         if (rd_fire && !at_last) idx_q <= idx_q + 4'd1;
         if (state_q == S_CAPTURE) idx_q <= '0;
         if (state_q == S_ISSUE) begin
            hold_addr_q <= addr_q;
            hold_cnt_q  <= cnt_q;
            hold_sel_q  <= sel_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS; i++) data_buf[i] <= '0;
      end else if (cmd_accept) begin
         for (int i = 0; i < WORDS; i++) data_buf[i] <= '0;
      end else if (wr_fire) begin
         data_buf[idx_q] <= wr_data;
      end else if (state_q == S_CAPTURE) begin
         for (int i = 0; i < WORDS; i++) data_buf[i] <= cpu_ram_output[i*DATA_W +: DATA_W];
      end
   end

   assign done    = done_q;
   assign cmd_err = err_q;

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed and randomized checks of cpu_cmd_sequencer against a transaction-level
// model: each legal command yields one CPU issue record, OutToRam data and RamToOut beats.
module tb_cpu_cmd_sequencer;
   localparam int WORDS = 16;
   localparam int DW    = 32;
   localparam int AW    = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                  cmd_valid = 1'b0;
   logic                  cmd_ready;
   logic [2:0]            cmd_op = '0;
   logic [AW-1:0]         cmd_addr = '0;
   logic [3:0]            cmd_cnt = '0;
   logic [1:0]            cmd_sel = '0;
   logic                  wr_valid = 1'b0;
   logic                  wr_ready;
   logic [DW-1:0]         wr_data = '0;
   logic                  rd_valid;
   logic                  rd_ready = 1'b0;
   logic [DW-1:0]         rd_data;
   logic                  rd_last;
   logic [2:0]            cpu_op;
   logic [AW-1:0]         cpu_ram_addr;
   logic [3:0]            cpu_ram_cnt;
   logic [1:0]            cpu_reg_sel;
   logic [WORDS*DW-1:0]   cpu_ram_input;
   logic [WORDS*DW-1:0]   cpu_ram_output = '0;
   logic                  busy;
   logic                  done;
   logic                  cmd_err;

   cpu_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_cnt(cmd_cnt), .cmd_sel(cmd_sel),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .cpu_op(cpu_op), .cpu_ram_addr(cpu_ram_addr), .cpu_ram_cnt(cpu_ram_cnt),
      .cpu_reg_sel(cpu_reg_sel), .cpu_ram_input(cpu_ram_input),
      .cpu_ram_output(cpu_ram_output),
      .busy(busy), .done(done), .cmd_err(cmd_err)
   );

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] wdata [WORDS];
   logic [DW-1:0] rout [WORDS];

   // observed CPU issues and read beats
   logic [2:0]          iss_op   [$];
   logic [AW-1:0]       iss_addr [$];
   logic [3:0]          iss_cnt  [$];
   logic [1:0]          iss_sel  [$];
   logic [WORDS*DW-1:0] iss_in   [$];
   int                  iss_cyc  [$];
   logic [DW-1:0]       rd_got   [$];
   logic                rd_lgot  [$];
   int                  rd_cyc   [$];
   int acc_cyc = -1, last_wr_cyc = -1, first_rdv_cyc = -1, last_done_cyc = -1;
   int done_cnt = 0, err_cnt = 0, consec_err = 0, hold_err = 0, wr_seen = 0, rd_seen = 0;
   logic prev_nonnop = 1'b0, prev_rdv = 1'b0, prev_rdr = 1'b0, prev_last = 1'b0;
   logic [DW-1:0] prev_rdata = '0;

   always @(negedge clk) begin
      if (cpu_op !== 3'b111) begin
         iss_op.push_back(cpu_op);
         iss_addr.push_back(cpu_ram_addr);
         iss_cnt.push_back(cpu_ram_cnt);
         iss_sel.push_back(cpu_reg_sel);
         iss_in.push_back(cpu_ram_input);
         iss_cyc.push_back(cyc);
         if (prev_nonnop) consec_err++;
         prev_nonnop = 1'b1;
      end else begin
         prev_nonnop = 1'b0;
      end
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (wr_valid && wr_ready) last_wr_cyc = cyc;
      if (wr_ready) wr_seen++;
      if (rd_valid) rd_seen++;
      if (rd_valid && !prev_rdv) first_rdv_cyc = cyc;
      if (prev_rdv && !prev_rdr) begin
         if (!rd_valid || rd_data !== prev_rdata || rd_last !== prev_last) hold_err++;
      end
      if (rd_valid && rd_ready) begin
         rd_got.push_back(rd_data);
         rd_lgot.push_back(rd_last);
         rd_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (cmd_err) err_cnt++;
      prev_rdv   = rd_valid;
      prev_rdr   = rd_ready;
      prev_rdata = rd_data;
      prev_last  = rd_last;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_obs();
      iss_op.delete(); iss_addr.delete(); iss_cnt.delete(); iss_sel.delete();
      iss_in.delete(); iss_cyc.delete();
      rd_got.delete(); rd_lgot.delete(); rd_cyc.delete();
      acc_cyc = -1; last_wr_cyc = -1; first_rdv_cyc = -1;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [AW-1:0] addr,
                           input logic [3:0] cnt, input logic [1:0] sel);
      bit ok = 1'b0;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_cnt = cnt; cmd_sel = sel;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic write_words(input int n);
      for (int i = 0; i < n; i++) begin
         bit ok = 1'b0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         wr_valid = 1'b1;
         wr_data  = wdata[i];
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wr_ready) begin ok = 1'b1; break; end
         end
         @(posedge clk); #1;
         wr_valid = 1'b0;
         if (!ok) begin check("wr_timeout", 64'd0, 64'd1); return; end
      end
   endtask

   task automatic drain_reads();
      bit got_last = 1'b0;
      for (int k = 0; k < 300 && !got_last; k++) begin
         rd_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         got_last = rd_valid && rd_ready && rd_last;
         @(posedge clk); #1;
      end
      rd_ready = 1'b0;
      if (!got_last) check("rd_last_timeout", 64'd0, 64'd1);
   endtask

   // Drives one command end-to-end and compares against the transaction model
   task automatic run_cmd(input string tag, input logic [2:0] op, input logic [AW-1:0] addr,
                          input logic [3:0] cnt, input logic [1:0] sel);
      int d0 = done_cnt;
      int e0 = err_cnt;
      bit legal = (op <= 3'b101);
      logic [DW-1:0] exp_w;
      clear_obs();
      for (int i = 0; i < WORDS; i++) cpu_ram_output[i*DW +: DW] = rout[i];
      send_cmd(op, addr, cnt, sel);
      if (op == 3'b101) write_words(int'(cnt) + 1);
      if (op == 3'b100) drain_reads();
      for (int k = 0; k < 10; k++) begin
         if (done_cnt != d0 || err_cnt != e0) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check({tag, "_issues"}, 64'(iss_op.size()), legal ? 64'd1 : 64'd0);
      check({tag, "_done"}, 64'(done_cnt - d0), legal ? 64'd1 : 64'd0);
      check({tag, "_err"}, 64'(err_cnt - e0), legal ? 64'd0 : 64'd1);
      if (!legal) begin
         check({tag, "_ready_after_err"}, 64'(cmd_ready), 64'd1);
      end else if (iss_op.size() == 1) begin
         check({tag, "_op"}, 64'(iss_op[0]), 64'(op));
         check({tag, "_addr"}, 64'(iss_addr[0]), 64'(addr));
         check({tag, "_cnt"}, 64'(iss_cnt[0]), 64'(cnt));
         check({tag, "_sel"}, 64'(iss_sel[0]), 64'(sel));
         for (int i = 0; i < WORDS; i++) begin
            exp_w = (op == 3'b101 && i <= int'(cnt)) ? wdata[i] : '0;
            check($sformatf("%s_in%0d", tag, i), 64'(iss_in[0][i*DW +: DW]), 64'(exp_w));
         end
         check({tag, "_issue_cyc"}, 64'(iss_cyc[0]),
               64'((op == 3'b101) ? last_wr_cyc + 1 : acc_cyc + 1));
         if (op == 3'b100) begin
            check({tag, "_first_rdv"}, 64'(first_rdv_cyc), 64'(acc_cyc + 3));
            check({tag, "_beats"}, 64'(rd_got.size()), 64'(int'(cnt) + 1));
            for (int i = 0; i < rd_got.size() && i < WORDS; i++) begin
               check($sformatf("%s_rd%0d", tag, i), 64'(rd_got[i]), 64'(rout[i]));
               check($sformatf("%s_last%0d", tag, i), 64'(rd_lgot[i]), 64'(i == int'(cnt)));
            end
            if (rd_cyc.size() > 0)
               check({tag, "_done_cyc"}, 64'(last_done_cyc), 64'(rd_cyc[rd_cyc.size()-1] + 1));
         end else begin
            check({tag, "_done_cyc"}, 64'(last_done_cyc), 64'(iss_cyc[0] + 1));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]    b_op   [4];
      logic [AW-1:0] b_addr [4];
      logic [1:0]    b_sel  [4];
      int d0, w0, r0;
      bit ok;

      // reset values
      #12;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cmd_err", 64'(cmd_err), 64'd0);
      check("rst_cpu_op", 64'(cpu_op), 64'd7);
      check("rst_cpu_addr", 64'(cpu_ram_addr), 64'd0);
      check("rst_ram_input_zero", 64'(|cpu_ram_input), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // full 16-word OutToRam with gaps
      for (int i = 0; i < WORDS; i++) wdata[i] = 32'h1000 + 32'(i);
      run_cmd("o2r16", 3'b101, 9'd10, 4'd15, 2'd0);

      // reset in the middle of a fill
      clear_obs();
      for (int i = 0; i < WORDS; i++) wdata[i] = $urandom;
      send_cmd(3'b101, 9'd20, 4'd15, 2'd1);
      write_words(5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
      check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("mid_rst_cpu_op", 64'(cpu_op), 64'd7);
      check("mid_rst_cpu_addr", 64'(cpu_ram_addr), 64'd0);
      check("mid_rst_cpu_cnt", 64'(cpu_ram_cnt), 64'd0);
      check("mid_rst_ram_input", 64'(|cpu_ram_input), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_no_issue", 64'(iss_op.size()), 64'd0);

      // RamToOut with CPU returning A0+i
      for (int i = 0; i < WORDS; i++) rout[i] = (i < 4) ? 32'hA0 + 32'(i) : $urandom;
      run_cmd("r2o4", 3'b100, 9'd100, 4'd3, 2'd0);
      check("r2o4_hold", 64'(hold_err), 64'd0);

      // back-to-back non-data commands
      clear_obs();
      d0 = done_cnt; w0 = wr_seen; r0 = rd_seen;
      b_op[0] = 3'b000; b_addr[0] = 9'd10;  b_sel[0] = 2'd0;
      b_op[1] = 3'b000; b_addr[1] = 9'd56;  b_sel[1] = 2'd1;
      b_op[2] = 3'b010; b_addr[2] = 9'd0;   b_sel[2] = 2'd0;
      b_op[3] = 3'b001; b_addr[3] = 9'd100; b_sel[3] = 2'd2;
      cmd_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cmd_op = b_op[k]; cmd_addr = b_addr[k]; cmd_cnt = 4'd0; cmd_sel = b_sel[k];
         ok = 1'b0;
         for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
         end
         @(posedge clk); #1;
         if (!ok) check("b2b_accept_timeout", 64'd0, 64'd1);
      end
      cmd_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("b2b_issues", 64'(iss_op.size()), 64'd4);
      for (int k = 0; k < 4 && k < iss_op.size(); k++) begin
         check($sformatf("b2b_op%0d", k), 64'(iss_op[k]), 64'(b_op[k]));
         check($sformatf("b2b_addr%0d", k), 64'(iss_addr[k]), 64'(b_addr[k]));
         check($sformatf("b2b_sel%0d", k), 64'(iss_sel[k]), 64'(b_sel[k]));
         if (k > 0) check($sformatf("b2b_gap%0d", k), 64'(iss_cyc[k] - iss_cyc[k-1]), 64'd2);
      end
      check("b2b_done", 64'(done_cnt - d0), 64'd4);
      check("b2b_no_wr", 64'(wr_seen - w0), 64'd0);
      check("b2b_no_rd", 64'(rd_seen - r0), 64'd0);

      // single-word OutToRam
      for (int i = 0; i < WORDS; i++) wdata[i] = $urandom;
      wdata[0] = 32'hDEADBEEF;
      run_cmd("o2r1", 3'b101, 9'd3, 4'd0, 2'd3);

      // illegal op
      run_cmd("illegal110", 3'b110, 9'd5, 4'd2, 2'd1);

      // randomized commands
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < WORDS; i++) begin
            wdata[i] = $urandom;
            rout[i]  = $urandom;
         end
         run_cmd($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      end

      check("never_consecutive_issue", 64'(consec_err), 64'd0);
      check("rd_data_held", 64'(hold_err), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
